// File: rtl/fp_square_seq.sv
// fp_square_seq: multi-cycle IEEE-754 single-precision squarer (S = A*A).
// Iterative shift-add mantissa multiplier, ITER_BITS multiplier bits per cycle.
// Denormals flush to zero, result sign is always positive.
// Optional round-to-nearest-even in NORM when FP_SQR_RNE_EN is defined;
// otherwise the product is truncated toward zero.
module fp_square_seq #(
  parameter int unsigned ITER_BITS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_A,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_S,
  output logic [2:0]  out_flags
);

  localparam int unsigned NumIter = 24 / ITER_BITS;

  typedef enum logic [1:0] {StIdle, StMul, StNorm, StDone} state_e;

  state_e      state_q, state_d;
  logic        rdy_en_q;
  logic [7:0]  exp_q, exp_d;
  logic [47:0] mcand_q, mcand_d;
  logic [23:0] mplr_q, mplr_d;
  logic [47:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] out_s_q, out_s_d;
  logic [2:0]  flags_q, flags_d;

  logic [47:0] partial;
  logic [31:0] norm_s;
  logic [2:0]  norm_flags;

  // Sum of the shifted multiplicand for the ITER_BITS multiplier bits of this cycle
  always_comb begin
    partial = '0;
    for (int j = 0; j < ITER_BITS; j++) begin
      if (mplr_q[j]) partial = partial + (mcand_q << j);
    end
  end

  // Normalise the 48-bit product, optionally round, and range-check the exponent
  logic        p_top;
  logic [9:0]  exp2;
  logic [9:0]  er;
  logic [9:0]  er_fin;
  logic [22:0] frac;
  logic [22:0] frac_fin;
`ifdef FP_SQR_RNE_EN
  logic        guard;
  logic        sticky;
  logic [23:0] rnd;
`else
  logic        unused_low;
  assign unused_low = ^acc_q[22:0];
`endif

  always_comb begin
    p_top  = acc_q[47];
    exp2   = {1'b0, exp_q, 1'b0};
    er     = p_top ? (exp2 - 10'd126) : (exp2 - 10'd127);
    frac   = p_top ? acc_q[46:24] : acc_q[45:23];
`ifdef FP_SQR_RNE_EN
    guard  = p_top ? acc_q[23] : acc_q[22];
    sticky = p_top ? (|acc_q[22:0]) : (|acc_q[21:0]);
    rnd    = {1'b0, frac} + {23'd0, guard & (sticky | frac[0])};
    // A carry out of the fraction bumps the exponent; rnd[22:0] is then zero
    er_fin   = rnd[23] ? (er + 10'd1) : er;
    frac_fin = rnd[22:0];
`else
    er_fin   = er;
    frac_fin = frac;
`endif
    norm_s     = {1'b0, er_fin[7:0], frac_fin};
    norm_flags = 3'b000;
    if ($signed(er_fin) >= 10'sd255) begin
      norm_s     = 32'h7F80_0000;
      norm_flags = 3'b100;
    end else if ($signed(er_fin) <= 10'sd0) begin
      norm_s     = 32'h0000_0000;
      norm_flags = 3'b010;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_s_d = out_s_q;
    flags_d = flags_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          exp_d   = in_A[30:23];
          mcand_d = {24'd0, 1'b1, in_A[22:0]};
          mplr_d  = {1'b1, in_A[22:0]};
          acc_d   = '0;
          cnt_d   = '0;
          if (in_A[30:23] == 8'hFF) begin
            if (in_A[22:0] != 23'd0) begin
              out_s_d = 32'h7FC0_0000;
              flags_d = 3'b001;
            end else begin
              out_s_d = 32'h7F80_0000;
              flags_d = 3'b000;
            end
            state_d = StDone;
          end else if (in_A[30:23] == 8'h00) begin
            out_s_d = 32'h0000_0000;
            flags_d = 3'b000;
            state_d = StDone;
          end else begin
            state_d = StMul;
          end
        end
      end
      StMul: begin
        acc_d   = acc_q + partial;
        mcand_d = mcand_q << ITER_BITS;
        mplr_d  = mplr_q >> ITER_BITS;
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == 5'(NumIter - 1)) state_d = StNorm;
      end
      StNorm: begin
        out_s_d = norm_s;
        flags_d = norm_flags;
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rdy_en_q <= 1'b0;
      exp_q    <= '0;
      mcand_q  <= '0;
      mplr_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      out_s_q  <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
      exp_q    <= exp_d;
      mcand_q  <= mcand_d;
      mplr_q   <= mplr_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      out_s_q  <= out_s_d;
      flags_q  <= flags_d;
    end
  end

  logic unused_sign;
  assign unused_sign = in_A[31];

  // rdy_en_q keeps in_ready low while reset is held, even though state is already idle
  assign in_ready  = (state_q == StIdle) && rdy_en_q;
  assign out_valid = (state_q == StDone);
  assign out_S     = out_s_q;
  assign out_flags = flags_q;

endmodule

// File: tb/tb_fp_square_seq.sv
// tb_fp_square_seq: directed self-checking bench for fp_square_seq.
// Honours FP_SQR_RNE_EN for the rounding vector.
module tb_fp_square_seq;

  localparam int unsigned ITER_BITS = 1;
  localparam int LatNorm = 24 / ITER_BITS + 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_A;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_S;
  logic [2:0]  out_flags;

  int total = 0;
  int bad   = 0;

  fp_square_seq #(.ITER_BITS(ITER_BITS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_A     (in_A),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_S    (out_S),
    .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp_v);
    end
  endtask

  // Present an operand and return #1 after its accept edge
  task automatic accept(input logic [31:0] a);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 100) check("accept_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_A     = a;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_A     = $urandom;
  endtask

  // Latency counts edges from the accept edge (inclusive) until out_valid is seen
  task automatic wait_result(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] s,
                        input logic [2:0] f, input int lat_exp);
    int lat;
    accept(a);
    wait_result(lat);
    check({tag, "_lat"}, 32'(lat), 32'(lat_exp));
    check({tag, "_S"}, out_S, s);
    check({tag, "_flags"}, 32'(out_flags), 32'(f));
    @(posedge clk); #1;
    check({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int  lat;
    bit  seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_A      = 32'h0;
    out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_S", out_S, 32'h0);
    check("rst_flags", 32'(out_flags), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);

    // Normal squares
    run_op("sq3", 32'h4040_0000, 32'h4110_0000, 3'b000, LatNorm);
    run_op("sqm1p5", 32'hBFC0_0000, 32'h4010_0000, 3'b000, LatNorm);

    // Special operands
    run_op("nan", 32'hFFC0_0001, 32'h7FC0_0000, 3'b001, 1);
    run_op("inf", 32'hFF80_0000, 32'h7F80_0000, 3'b000, 1);
    run_op("denorm", 32'h0040_0000, 32'h0000_0000, 3'b000, 1);

    // Range limits
    run_op("ovf", 32'h60AD_78EC, 32'h7F80_0000, 3'b100, LatNorm);
    run_op("unf", 32'h1500_0000, 32'h0000_0000, 3'b010, LatNorm);

    // Rounding
`ifdef FP_SQR_RNE_EN
    run_op("round", 32'h3FC0_0001, 32'h4010_0002, 3'b000, LatNorm);
`else
    run_op("round", 32'h3FC0_0001, 32'h4010_0001, 3'b000, LatNorm);
`endif

    // Backpressure: result held, no new accept while in DONE
    out_ready = 1'b0;
    accept(32'h4040_0000);
    wait_result(lat);
    check("bp_lat", 32'(lat), 32'(LatNorm));
    check("bp_S0", out_S, 32'h4110_0000);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        in_valid = 1'b1;
        in_A     = 32'h4000_0000;
      end
      @(posedge clk); #1;
      check("bp_hold_S", out_S, 32'h4110_0000);
      check("bp_hold_vld", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_hs_vld", 32'(out_valid), 32'd0);
    check("bp_hs_rdy", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_A     = $urandom;
    check("bp_acc_rdy", 32'(in_ready), 32'd0);
    wait_result(lat);
    check("bp2_lat", 32'(lat), 32'(LatNorm));
    check("bp2_S", out_S, 32'h4080_0000);
    @(posedge clk); #1;
    check("bp2_vld_drop", 32'(out_valid), 32'd0);

    // Reset in the middle of MUL
    accept(32'h4040_0000);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mrst_rdy_low", 32'(in_ready), 32'd0);
    check("mrst_vld_low", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mrst_rdy_high", 32'(in_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("mrst_no_result", 32'(seen), 32'd0);
    run_op("after_rst", 32'h4000_0000, 32'h4080_0000, 3'b000, LatNorm);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_square_seq.md
Name: fp_square_seq

Overview:
- Multi-cycle IEEE-754 single-precision squarer: S = A*A. It is the inverse operation of the FPAU square-root path.
- Iterative shift-add mantissa multiplier with valid/ready handshakes on input and output.
- Sits beside the root-square unit in the FPAU. Uses the same special-value policy:
  - denormals flushed to zero;
  - result sign is always +.

Parameters:
- ITER_BITS, 1: multiplier bits consumed per MUL cycle. Legal values are 1, 2, 3, 4, 6, 8, 12, 24. MUL phase takes 24/ITER_BITS cycles.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operand valid.
- in_ready  output  1  block can accept an operand.
- in_A  input  32  IEEE-754 single operand.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_S  output  32  IEEE-754 single result.
- out_flags  output  3  {overflow, underflow, nan_in}; valid with out_valid.

Behaviour:
- Reset: in effect at any clk edge with rst_n=0.
  - State goes to IDLE.
  - in_ready=0 during reset, then 1 from the first edge after rst_n=1.
  - out_valid=0, out_S=0, out_flags=0.
  - An operation in progress is discarded; no partial result appears.
- FSM states: IDLE, MUL, NORM, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch in_A. Mantissa M = {1, frac}; E = exp field.
  - Special operand: go to DONE, result ready the next cycle (latency 1).
  - Otherwise clear the 48-bit accumulator and go to MUL.
- MUL:
  - Each cycle adds M shifted by the current multiplier bit position for ITER_BITS bits of M.
  - After 24/ITER_BITS cycles, go to NORM.
  - in_ready=0.
- NORM: one cycle.
  - P = M*M, 48 bits, P in [2^46, 2^48).
  - If P[47]=1: frac = P[46:24], Er = 2E-126.
  - Else: frac = P[45:23], Er = 2E-127.
  - Er is computed in 10-bit signed arithmetic.
  - Er >= 255: out_S = 0x7F800000, overflow=1.
  - Er <= 0: out_S = 0x00000000, underflow=1.
  - Otherwise out_S = {0, Er[7:0], frac}.
  - Go to DONE.
- DONE:
  - out_valid=1.
  - out_S and out_flags are held stable until out_valid&out_ready.
  - Then go to IDLE, with out_valid=0 on the next cycle.
  - in_ready=0 in DONE. There is no overlap of accept with output.
- Normal latency: accept edge to out_valid = 24/ITER_BITS + 2 cycles. This is 26 cycles with ITER_BITS=1.
- Special operands, checked in order:
  - NaN (E=255, frac≠0): out_S = 0x7FC00000, nan_in=1.
  - Inf (E=255, frac=0): out_S = 0x7F800000, no flags.
  - Zero or denormal (E=0): out_S = 0x00000000, no flags.
- Sign of A is ignored; result sign bit is always 0.
- in_A is sampled only on the accept edge. Changes to in_A afterwards have no effect.
- Rounding without the optional feature: truncation toward zero.

Optional Feature:
- Macro: FP_SQR_RNE_EN.
- When defined:
  - NORM applies round-to-nearest-even. Guard bit is the bit below frac; sticky is the OR of all lower product bits.
  - Increment frac when guard & (sticky | frac[0]).
  - A carry out of frac increments Er and sets frac=0.
  - The overflow check uses the post-rounding Er.
  - NORM latency is unchanged.
- When undefined: truncation. Guard/sticky logic is not instantiated.

Test Plan:
- Normal squares: in_A=0x40400000 (3.0), out_ready=1.
  - out_S=0x41100000 (9.0), flags=000.
  - out_valid asserted exactly 26 cycles after accept (ITER_BITS=1).
  - Also: in_A=0xBFC00000 (-1.5) gives out_S=0x40100000.
- Special values: each result appears 1 cycle after accept.
  - in_A=0xFFC00001 gives 0x7FC00000, flags=001.
  - in_A=0xFF800000 gives 0x7F800000, flags=000.
  - in_A=0x00400000 (denormal) gives 0x00000000, flags=000.
- Range limits:
  - in_A=0x60AD78EC (1e20) gives 0x7F800000, flags=100.
  - in_A=0x15000000 (E=42) gives 0x00000000, flags=010.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid. out_S must stay stable and in_ready=0.
  - Assert in_valid with a new operand during that time. It must not be accepted until the cycle after the output handshake.
- Reset mid-operation:
  - Drive rst_n=0 for 1 cycle at MUL cycle 10.
  - out_valid must never assert for that operand; in_ready=1 the cycle after release.
  - The next operand 0x40000000 gives 0x40800000.
- Rounding:
  - in_A=0x3FC00001 gives 0x40100001 without FP_SQR_RNE_EN.
  - The same operand gives 0x40100002 with FP_SQR_RNE_EN.
  - Also check ITER_BITS=8: the first normal-square case then has latency 5.
